// File: rtl/alarm_match_unit.sv
// Multi-channel alarm comparator with per-channel ring timer.
// Each channel arms on a level, triggers on the rising edge of a time match,
// rings for RING_TICKS tick strobes or until acknowledged.
// Optional feature macro: ALARM_MATCH_SNOOZE_EN adds the snooze port and SNOOZE state.
module alarm_match_unit #(
    parameter int unsigned NCH          = 2,
    parameter int unsigned W            = 8,
    parameter int unsigned RING_TICKS   = 30,
    parameter int unsigned SNOOZE_TICKS = 60
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en,
    input  logic               tick,
    input  logic [NCH*W-1:0]   prog_h,
    input  logic [NCH*W-1:0]   prog_m,
    input  logic [NCH*W-1:0]   prog_s,
    input  logic [W-1:0]       count_h,
    input  logic [W-1:0]       count_m,
    input  logic [W-1:0]       count_s,
    input  logic [NCH-1:0]     arm,
    input  logic [NCH-1:0]     ack,
`ifdef ALARM_MATCH_SNOOZE_EN
    input  logic [NCH-1:0]     snooze,
`endif
    output logic [NCH-1:0]     fin,
    output logic               fin_any,
    output logic               fire
);

    typedef enum logic [1:0] {StIdle, StArmed, StRinging, StSnooze} state_e;

    localparam logic [7:0] RingLoad   = 8'(RING_TICKS);
    localparam logic [7:0] SnoozeLoad = 8'(SNOOZE_TICKS);

    state_e         state_q [NCH];
    state_e         state_d [NCH];
    logic [7:0]     cnt_q   [NCH];
    logic [7:0]     cnt_d   [NCH];
    logic [NCH-1:0] match;
    logic [NCH-1:0] match_q;
    logic [NCH-1:0] fin_q, fin_d;
    logic           fire_q, fire_d;
    logic [NCH-1:0] snooze_req;
    logic           tick_en;

`ifdef ALARM_MATCH_SNOOZE_EN
    assign snooze_req = snooze;
`else
    // Tied off so the SNOOZE state is unreachable and gets optimised away.
    assign snooze_req = '0;
`endif

    assign tick_en = tick & en;

    // Per-channel time compare; an all-zero programmed time never matches.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            match[i] = (prog_h[i*W +: W] == count_h) &&
                       (prog_m[i*W +: W] == count_m) &&
                       (prog_s[i*W +: W] == count_s) &&
                       (|{prog_h[i*W +: W], prog_m[i*W +: W], prog_s[i*W +: W]});
        end
    end

    // Channel FSMs: priority is disarm > ack > snooze > tick expiry > trigger.
    always_comb begin
        logic trig;
        fire_d = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            trig       = match[i] & ~match_q[i] & en;
            unique case (state_q[i])
                StIdle: begin
                    if (arm[i]) begin
                        state_d[i] = StArmed;
                    end
                end
                StArmed: begin
                    if (!arm[i]) begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = 8'd0;
                    end else if (trig) begin
                        state_d[i] = StRinging;
                        cnt_d[i]   = RingLoad;
                        fire_d     = 1'b1;
                    end
                end
                StRinging: begin
                    if (!arm[i]) begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = 8'd0;
                    end else if (ack[i]) begin
                        state_d[i] = StArmed;
                        cnt_d[i]   = 8'd0;
                    end else if (snooze_req[i]) begin
                        state_d[i] = StSnooze;
                        cnt_d[i]   = SnoozeLoad;
                    end else if (tick_en) begin
                        if (cnt_q[i] <= 8'd1) begin
                            state_d[i] = StArmed;
                            cnt_d[i]   = 8'd0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - 8'd1;
                        end
                    end
                end
                StSnooze: begin
                    if (!arm[i]) begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = 8'd0;
                    end else if (ack[i]) begin
                        state_d[i] = StArmed;
                        cnt_d[i]   = 8'd0;
                    end else if (tick_en) begin
                        // Snooze expiry resumes ringing without a fire pulse.
                        if (cnt_q[i] <= 8'd1) begin
                            state_d[i] = StRinging;
                            cnt_d[i]   = RingLoad;
                        end else begin
                            cnt_d[i] = cnt_q[i] - 8'd1;
                        end
                    end
                end
            endcase
            fin_d[i] = (state_d[i] == StRinging);
        end
    end

    // State, counters and registered outputs; match_q updates even when en is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= 8'd0;
            end
            match_q <= '0;
            fin_q   <= '0;
            fire_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            match_q <= match;
            fin_q   <= fin_d;
            fire_q  <= fire_d;
        end
    end

    assign fin     = fin_q;
    assign fin_any = |fin_q;
    assign fire    = fire_q;

endmodule

// File: tb/tb_alarm_match_unit.sv
// Scoreboard bench for alarm_match_unit: the driver pushes the expected
// registered outputs for every clock edge, the monitor pops and compares.
module tb_alarm_match_unit;

    localparam int unsigned NCH = 2;
    localparam int unsigned W   = 8;

    logic             clock = 1'b0;
    logic             reset, en, tick;
    logic [NCH*W-1:0] prog_h, prog_m, prog_s;
    logic [W-1:0]     count_h, count_m, count_s;
    logic [NCH-1:0]   arm, ack;
    logic [NCH-1:0]   snooze;
    logic [NCH-1:0]   fin;
    logic             fin_any, fire;

    typedef struct {
        logic [NCH-1:0] fin;
        logic           fire;
        logic           fin_any;
        string          name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    alarm_match_unit #(
        .NCH          (NCH),
        .W            (W),
        .RING_TICKS   (3),
        .SNOOZE_TICKS (2)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .en      (en),
        .tick    (tick),
        .prog_h  (prog_h),
        .prog_m  (prog_m),
        .prog_s  (prog_s),
        .count_h (count_h),
        .count_m (count_m),
        .count_s (count_s),
        .arm     (arm),
        .ack     (ack),
`ifdef ALARM_MATCH_SNOOZE_EN
        .snooze  (snooze),
`endif
        .fin     (fin),
        .fin_any (fin_any),
        .fire    (fire)
    );

    // Monitor: compare outputs after each edge against the scoreboard head.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (fin !== e.fin || fire !== e.fire || fin_any !== e.fin_any) begin
                n_fail++;
                $display("FAIL %s: got fin=%b fire=%b fin_any=%b, expected fin=%b fire=%b fin_any=%b",
                         e.name, fin, fire, fin_any, e.fin, e.fire, e.fin_any);
            end
        end
    end

    // One clock edge with the current inputs; record what must appear after it.
    task automatic step(input logic [NCH-1:0] f, input logic fr, input string name);
        exp_t e;
        @(posedge clock);
        e.fin     = f;
        e.fire    = fr;
        e.fin_any = |f;
        e.name    = name;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    task automatic set_time(input logic [W-1:0] h, input logic [W-1:0] m, input logic [W-1:0] s);
        count_h = h;
        count_m = m;
        count_s = s;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; tick = 1'b0;
        prog_h = '0; prog_m = '0; prog_s = '0;
        arm = '0; ack = '0; snooze = '0;
        set_time(8'd0, 8'd0, 8'd0);

        step(2'b00, 1'b0, "reset_0");
        step(2'b00, 1'b0, "reset_1");
        reset = 1'b0;

        // Ch0 alarm 07:30:00, ch1 left unprogrammed.
        prog_h[0 +: W] = 8'd7; prog_m[0 +: W] = 8'd30; prog_s[0 +: W] = 8'd0;
        set_time(8'd7, 8'd29, 8'd59);
        arm = 2'b01;
        step(2'b00, 1'b0, "arm_ch0");
        step(2'b00, 1'b0, "armed_wait");
        set_time(8'd7, 8'd30, 8'd0);
        step(2'b01, 1'b1, "match_fire");
        step(2'b01, 1'b0, "ringing_hold");

        // Ring timeout after three ticks; held match must not re-trigger.
        tick = 1'b1; step(2'b01, 1'b0, "tick1");
        tick = 1'b0; step(2'b01, 1'b0, "gap1");
        tick = 1'b1; step(2'b01, 1'b0, "tick2");
        tick = 1'b0; step(2'b01, 1'b0, "gap2");
        tick = 1'b1; step(2'b00, 1'b0, "tick3_timeout");
        tick = 1'b0; step(2'b00, 1'b0, "no_retrig_0");
        step(2'b00, 1'b0, "no_retrig_1");

        // Ack together with disarm -> IDLE, later match ignored.
        set_time(8'd7, 8'd30, 8'd1); step(2'b00, 1'b0, "off_match");
        set_time(8'd7, 8'd30, 8'd0); step(2'b01, 1'b1, "retrigger");
        ack = 2'b01; arm = 2'b00; step(2'b00, 1'b0, "ack_disarm");
        ack = 2'b00;
        set_time(8'd7, 8'd30, 8'd1); step(2'b00, 1'b0, "idle_off");
        set_time(8'd7, 8'd30, 8'd0); step(2'b00, 1'b0, "idle_match_ignored");

        // Ack with arm high -> ARMED; match lasting after ack does not re-trigger.
        arm = 2'b01; step(2'b00, 1'b0, "rearm");
        set_time(8'd7, 8'd30, 8'd1); step(2'b00, 1'b0, "rearm_off");
        set_time(8'd7, 8'd30, 8'd0); step(2'b01, 1'b1, "rearm_fire");
        ack = 2'b01; step(2'b00, 1'b0, "ack_only");
        ack = 2'b00; step(2'b00, 1'b0, "after_ack_0");
        step(2'b00, 1'b0, "after_ack_1");

        // Match appearing while en=0 must not trigger when en rises.
        set_time(8'd7, 8'd30, 8'd1); step(2'b00, 1'b0, "en_pre");
        en = 1'b0; set_time(8'd7, 8'd30, 8'd0); step(2'b00, 1'b0, "en_low_match");
        en = 1'b1; step(2'b00, 1'b0, "en_rise_no_trig");

        // Ringing while en=0: ticks do not count down.
        set_time(8'd7, 8'd30, 8'd1); step(2'b00, 1'b0, "en_ring_pre");
        set_time(8'd7, 8'd30, 8'd0); step(2'b01, 1'b1, "en_ring_fire");
        en = 1'b0; tick = 1'b1;
        repeat (4) step(2'b01, 1'b0, "en_low_ticks_hold");
        en = 1'b1; tick = 1'b0; ack = 2'b01; step(2'b00, 1'b0, "en_ring_ack");
        ack = 2'b00;

        // All-zero programmed time never matches.
        prog_h = '0; prog_m = '0; prog_s = '0;
        set_time(8'd0, 8'd0, 8'd0);
        arm = 2'b11;
        step(2'b00, 1'b0, "zero_0");
        step(2'b00, 1'b0, "zero_1");
        step(2'b00, 1'b0, "zero_2");

        // Both channels 12:00:00 -> single fire pulse, then reset mid-ring.
        prog_h = {8'd12, 8'd12};
        set_time(8'd11, 8'd59, 8'd59); step(2'b00, 1'b0, "both_pre");
        set_time(8'd12, 8'd0, 8'd0);   step(2'b11, 1'b1, "both_fire");
        reset = 1'b1;                  step(2'b00, 1'b0, "reset_mid_ring");
        reset = 1'b0;                  step(2'b00, 1'b0, "post_reset_arm");
        step(2'b00, 1'b0, "post_reset_no_trig");

`ifdef ALARM_MATCH_SNOOZE_EN
        // Snooze: fin drops, returns after two ticks without fire.
        set_time(8'd12, 8'd0, 8'd1); step(2'b00, 1'b0, "snz_pre");
        arm = 2'b01;
        set_time(8'd12, 8'd0, 8'd0); step(2'b01, 1'b1, "snz_fire");
        snooze = 2'b01; step(2'b00, 1'b0, "snz_enter");
        snooze = 2'b00;
        tick = 1'b1; step(2'b00, 1'b0, "snz_tick1");
        tick = 1'b0; step(2'b00, 1'b0, "snz_gap");
        tick = 1'b1; step(2'b01, 1'b0, "snz_resume_no_fire");
        tick = 1'b0; step(2'b01, 1'b0, "snz_ringing");
        ack = 2'b01; step(2'b00, 1'b0, "snz_ack");
        ack = 2'b00;
`endif

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clock);
        @(negedge clock);
        @(negedge clock);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_match_unit.md
ALARM_MATCH_UNIT -- requirements
Module: alarm_match_unit

Interface
REQ-001 Parameter NCH, default 2: number of independent alarm channels, range 1..8.
REQ-002 Parameter W, default 8: width of each time field (hours, minutes, seconds).
REQ-003 Parameter RING_TICKS, default 30: ring duration in tick strobes, range 1..255.
REQ-004 Parameter SNOOZE_TICKS, default 60: snooze duration in tick strobes, range 1..255; used only with SNOOZE_EN.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 en  in  1  compare enable; match detection and tick counting only while high.
REQ-008 tick  in  1  one-cycle time-base strobe (1 Hz nominal).
REQ-009 prog_h, prog_m, prog_s  in  NCH*W each  programmed alarm time; channel i occupies bits [i*W +: W].
REQ-010 count_h, count_m, count_s  in  W each  current time from the clock counter.
REQ-011 arm  in  NCH  per-channel arm level; 0 disarms.
REQ-012 ack  in  NCH  per-channel acknowledge, level-sampled.
REQ-013 snooze  in  NCH  per-channel snooze request; present only with SNOOZE_EN.
REQ-014 fin  out  NCH  per-channel ringing indication.
REQ-015 fin_any  out  1  OR of fin.
REQ-016 fire  out  1  one-cycle pulse when any channel enters RINGING from ARMED.

Function
REQ-017 match[i] SHALL be true when all three fields of channel i equal the count fields and the programmed time is not 00:00:00.
REQ-018 Each channel SHALL register match[i] (match_q[i]); a trigger SHALL occur only on a rising edge (match[i]=1, match_q[i]=0) with en=1.
REQ-019 Each channel SHALL run an independent FSM with states IDLE, ARMED, RINGING, SNOOZE, plus an 8-bit down-counter.
REQ-020 IDLE: arm[i]=1 -> ARMED on the next edge.
REQ-021 ARMED: arm[i]=0 -> IDLE; trigger -> RINGING, counter loaded with RING_TICKS.
REQ-022 RINGING: each tick with en=1 decrements the counter; a decrement from 1 to 0 -> ARMED (timeout).
REQ-023 RINGING/SNOOZE: ack[i]=1 -> ARMED, counter cleared.
REQ-024 SNOOZE: each tick with en=1 decrements; a decrement from 1 to 0 -> RINGING, counter reloaded with RING_TICKS; no fire pulse.
REQ-025 Priority within one cycle: arm[i]=0 > ack[i] > snooze[i] > tick expiry > trigger.
REQ-026 fin[i] SHALL be registered and high exactly while channel i is in RINGING, rising on the same edge the state enters RINGING (one cycle after match appears).
REQ-027 With en=0, states and counters SHALL hold except for arm and ack transitions; match_q SHALL still update, so a match present when en rises does not trigger.
REQ-028 Because triggering is edge-based, a match lasting a full second after ack SHALL NOT re-trigger.
REQ-029 Simultaneous triggers on several channels SHALL produce a single one-cycle fire pulse.

Reset
REQ-030 On reset: all channels IDLE, counters 0, match_q 0, fin 0, fin_any 0, fire 0.
REQ-031 Reset mid-ring SHALL clear fin on the next edge and require re-arming.

Configuration
REQ-032 Macro ALARM_MATCH_SNOOZE_EN defined: the snooze port exists; snooze[i]=1 in RINGING -> SNOOZE, counter loaded with SNOOZE_TICKS.
REQ-033 Macro ALARM_MATCH_SNOOZE_EN undefined: no snooze port, SNOOZE state unreachable and optimised out, SNOOZE_TICKS ignored.

Verification
REQ-034 NCH=2, prog ch0 07:30:00, arm=01, count steps 07:29:59 -> 07:30:00 -> fin=01 after one edge, fire one pulse, fin_any=1.
REQ-035 Ringing ch0, RING_TICKS=3, three ticks with no ack -> fin[0] falls on the third tick, state ARMED, no re-trigger while count holds 07:30:00.
REQ-036 Ringing ch0, ack[0]=1 with arm[0]=0 in the same cycle -> IDLE; later matching time -> no fin.
REQ-037 Program 00:00:00 with count 00:00:00 and arm=11 -> fin stays 00.
REQ-038 SNOOZE_EN, SNOOZE_TICKS=2: snooze[0] while ringing -> fin[0]=0; after 2 ticks -> fin[0]=1, no fire pulse.
REQ-039 Both channels programmed 12:00:00 and armed -> fin=11, single fire pulse; reset next cycle -> all outputs 0.
